// File: rtl/noc_packet_injector_pkg.sv
// Shared widths and the default packet layout for the resource-side NoC injector.
package noc_packet_injector_pkg;

   localparam int unsigned DEF_COL_W  = 4;
   localparam int unsigned DEF_ROW_W  = 4;
   localparam int unsigned DEF_SEQ_W  = 4;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_FIFO_DEPTH_W = 2;

   localparam int unsigned CNT_W   = 8;
   localparam int unsigned CNT_MAX = 255;

   // Packet layout at default widths, MSB first; the router slices col/row from the top bits.
   typedef struct packed {
      logic [DEF_COL_W-1:0]  col;
      logic [DEF_ROW_W-1:0]  row;
      logic [DEF_SEQ_W-1:0]  seq;
      logic [DEF_DATA_W-1:0] data;
   } pkt_t;

endpackage

// File: rtl/noc_packet_injector_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty; reusable for switch input buffers.
module sync_fifo #(
   parameter int unsigned WIDTH   = 20,
   parameter int unsigned DEPTH_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_W;
   localparam int unsigned PTR_W = DEPTH_W + 1;

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic w_push;
   logic w_pop;

   assign empty_o = (r_wr_ptr == r_rd_ptr);
   assign full_o  = (r_wr_ptr[DEPTH_W] != r_rd_ptr[DEPTH_W]) &&
                    (r_wr_ptr[DEPTH_W-1:0] == r_rd_ptr[DEPTH_W-1:0]);

   // Pushes are blocked while full even if a pop happens in the same cycle.
   assign w_push = push_i & ~full_o;
   assign w_pop  = pop_i & ~empty_o;

   assign head_o = r_mem[r_rd_ptr[DEPTH_W-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_W-1:0]] <= data_i;
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
      end
   end

endmodule

// File: rtl/noc_packet_injector.sv
// Resource-side packet injector: checks destinations, stamps sequence numbers and
// queues packets toward the switch RESOURCE input over valid/ready.
module noc_packet_injector
   import noc_packet_injector_pkg::*;
#(
   parameter int unsigned COL_CORD          = 0,
   parameter int unsigned ROW_CORD          = 0,
   parameter int unsigned MESH_COLS         = 4,
   parameter int unsigned MESH_ROWS         = 4,
   parameter int unsigned PACKET_ADDR_COL_W = DEF_COL_W,
   parameter int unsigned PACKET_ADDR_ROW_W = DEF_ROW_W,
   parameter int unsigned SEQ_W             = DEF_SEQ_W,
   parameter int unsigned DATA_W            = DEF_DATA_W,
   parameter int unsigned FIFO_DEPTH_W      = DEF_FIFO_DEPTH_W
) (
   input  logic                                                       clk_i,
   input  logic                                                       rst_ni,
   input  logic                                                       req_valid_i,
   output logic                                                       req_ready_o,
   input  logic [PACKET_ADDR_COL_W-1:0]                               req_col_i,
   input  logic [PACKET_ADDR_ROW_W-1:0]                               req_row_i,
   input  logic [DATA_W-1:0]                                          req_data_i,
   output logic                                                       pkt_valid_o,
   input  logic                                                       pkt_ready_i,
   output logic [PACKET_ADDR_COL_W+PACKET_ADDR_ROW_W+SEQ_W+DATA_W-1:0] pkt_o,
   output logic                                                       err_o,
   output logic [CNT_W-1:0]                                           drop_cnt_o,
   output logic [CNT_W-1:0]                                           sent_cnt_o
);

   localparam int unsigned COL_W = PACKET_ADDR_COL_W;
   localparam int unsigned ROW_W = PACKET_ADDR_ROW_W;
   localparam int unsigned PKT_W = COL_W + ROW_W + SEQ_W + DATA_W;

   // Coordinates and mesh bounds truncated to field widths, matching the router's view.
   logic [COL_W-1:0] w_own_col;
   logic [ROW_W-1:0] w_own_row;
   logic [COL_W-1:0] w_mesh_cols;
   logic [ROW_W-1:0] w_mesh_rows;

   assign w_own_col   = COL_W'(COL_CORD);
   assign w_own_row   = ROW_W'(ROW_CORD);
   assign w_mesh_cols = COL_W'(MESH_COLS);
   assign w_mesh_rows = ROW_W'(MESH_ROWS);

   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_accept;
   logic             w_legal;
   logic             w_push;
   logic             w_pop;
   logic [PKT_W-1:0] w_pkt;

   logic [SEQ_W-1:0] r_seq;
   logic             r_err;
   logic [CNT_W-1:0] r_drop_cnt;
   logic [CNT_W-1:0] r_sent_cnt;

   assign req_ready_o = ~w_fifo_full;
   assign w_accept    = req_valid_i & req_ready_o;
   assign w_legal     = (req_col_i < w_mesh_cols) && (req_row_i < w_mesh_rows) &&
                        !((req_col_i == w_own_col) && (req_row_i == w_own_row));
   assign w_push      = w_accept & w_legal;

   assign pkt_valid_o = ~w_fifo_empty;
   assign w_pop       = pkt_valid_o & pkt_ready_i;
   assign w_pkt       = {req_col_i, req_row_i, r_seq, req_data_i};

   sync_fifo #(
      .WIDTH   (PKT_W),
      .DEPTH_W (FIFO_DEPTH_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push),
      .data_i  (w_pkt),
      .pop_i   (w_pop),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty),
      .head_o  (pkt_o)
   );

   // Sequence number advances only on injected packets.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_seq <= '0;
      end else if (w_push) begin
         r_seq <= r_seq + SEQ_W'(1);
      end
   end

   // Rejection pulse and statistics.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err      <= 1'b0;
         r_drop_cnt <= '0;
         r_sent_cnt <= '0;
      end else begin
         r_err <= w_accept & ~w_legal;
         if (w_accept && !w_legal && (r_drop_cnt != CNT_W'(CNT_MAX))) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         end
         if (w_pop) begin
            r_sent_cnt <= r_sent_cnt + CNT_W'(1);
         end
      end
   end

   assign err_o      = r_err;
   assign drop_cnt_o = r_drop_cnt;
   assign sent_cnt_o = r_sent_cnt;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Self-checking bench for noc_packet_injector at node (1,1) in a 4x4 mesh.
module tb_noc_packet_injector;
   import noc_packet_injector_pkg::*;

   logic        clk_i;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [3:0]  req_col_i;
   logic [3:0]  req_row_i;
   logic [7:0]  req_data_i;
   logic        pkt_valid_o;
   logic        pkt_ready_i;
   logic [19:0] pkt_o;
   logic        err_o;
   logic [7:0]  drop_cnt_o;
   logic [7:0]  sent_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   noc_packet_injector #(
      .COL_CORD (1),
      .ROW_CORD (1),
      .MESH_COLS(4),
      .MESH_ROWS(4)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_col_i   (req_col_i),
      .req_row_i   (req_row_i),
      .req_data_i  (req_data_i),
      .pkt_valid_o (pkt_valid_o),
      .pkt_ready_i (pkt_ready_i),
      .pkt_o       (pkt_o),
      .err_o       (err_o),
      .drop_cnt_o  (drop_cnt_o),
      .sent_cnt_o  (sent_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      int          col;
      int          row;
      int          data;
      logic        exp_err;
      logic [19:0] exp_pkt;
   } vec_t;

   function automatic logic [19:0] mk(int c, int r, int s, int d);
      pkt_t p;
      p.col  = 4'(c);
      p.row  = 4'(r);
      p.seq  = 4'(s);
      p.data = 8'(d);
      return p;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_req(logic v, int c, int r, int d);
      req_valid_i = v;
      req_col_i   = 4'(c);
      req_row_i   = 4'(r);
      req_data_i  = 8'(d);
   endtask

   // Leaves the bench at a negedge with reset released and everything idle.
   task automatic do_reset();
      rst_ni = 1'b0;
      drive_req(1'b0, 0, 0, 0);
      pkt_ready_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_pkt_valid", 32'(pkt_valid_o), 0);
      check("rst_pkt", 32'(pkt_o), 0);
      check("rst_err", 32'(err_o), 0);
      check("rst_ready", 32'(req_ready_o), 1);
      check("rst_drop", 32'(drop_cnt_o), 0);
      check("rst_sent", 32'(sent_cnt_o), 0);
      rst_ni = 1'b1;
   endtask

   // Behavioural model state for the random phase.
   logic [19:0] m_q[$];
   int          m_seq;
   int          m_drop;
   int          m_sent;
   logic        m_err;

   task automatic rnd_step();
      logic v, rdy, legal, acc, pop;
      int c, r, d;
      check("rnd_valid", 32'(pkt_valid_o), 32'(m_q.size() != 0));
      check("rnd_ready", 32'(req_ready_o), 32'(m_q.size() < 4));
      if (m_q.size() != 0) check("rnd_pkt", 32'(pkt_o), 32'(m_q[0]));
      check("rnd_err", 32'(err_o), 32'(m_err));
      check("rnd_drop", 32'(drop_cnt_o), 32'(m_drop));
      check("rnd_sent", 32'(sent_cnt_o), 32'(m_sent));
      v   = 1'($urandom_range(0, 1));
      c   = $urandom_range(0, 5);
      r   = $urandom_range(0, 5);
      d   = $urandom_range(0, 255);
      rdy = ($urandom_range(0, 3) != 0);
      drive_req(v, c, r, d);
      pkt_ready_i = rdy;
      legal = (c < 4) && (r < 4) && !(c == 1 && r == 1);
      acc   = v && (m_q.size() < 4);
      pop   = rdy && (m_q.size() != 0);
      m_err = acc && !legal;
      if (acc && !legal && m_drop < 255) m_drop++;
      if (pop) begin
         void'(m_q.pop_front());
         m_sent = (m_sent + 1) % 256;
      end
      if (acc && legal) begin
         m_q.push_back(mk(c, r, m_seq, d));
         m_seq = (m_seq + 1) % 16;
      end
      @(negedge clk_i);
   endtask

   initial begin
      vec_t        vt[8];
      logic [19:0] got[$];
      logic        took;
      int          cyc;

      rst_ni = 1'b0;
      drive_req(1'b0, 0, 0, 0);
      pkt_ready_i = 1'b0;

      // Table: single requests into an empty FIFO with the switch always ready.
      vt[0] = '{3, 0, 8'hA5, 1'b0, 20'h300A5};
      vt[1] = '{1, 1, 8'h3C, 1'b1, 20'h0};
      vt[2] = '{4, 2, 8'h10, 1'b1, 20'h0};
      vt[3] = '{0, 0, 8'h11, 1'b0, 20'h00111};
      vt[4] = '{3, 3, 8'hFF, 1'b0, 20'h332FF};
      vt[5] = '{2, 4, 8'h20, 1'b1, 20'h0};
      vt[6] = '{1, 0, 8'h5A, 1'b0, 20'h1035A};
      vt[7] = '{0, 1, 8'h77, 1'b0, 20'h01477};

      do_reset();
      pkt_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive_req(1'b1, vt[i].col, vt[i].row, vt[i].data);
         @(posedge clk_i);
         @(negedge clk_i);
         check($sformatf("tbl%0d_err", i), 32'(err_o), 32'(vt[i].exp_err));
         check($sformatf("tbl%0d_valid", i), 32'(pkt_valid_o), 32'(!vt[i].exp_err));
         if (!vt[i].exp_err) check($sformatf("tbl%0d_pkt", i), 32'(pkt_o), 32'(vt[i].exp_pkt));
         req_valid_i = 1'b0;
         @(posedge clk_i);
         @(negedge clk_i);
         check($sformatf("tbl%0d_err_clr", i), 32'(err_o), 0);
      end
      check("tbl_drop", 32'(drop_cnt_o), 3);
      check("tbl_sent", 32'(sent_cnt_o), 5);

      // Drop counter saturation.
      do_reset();
      drive_req(1'b1, 4, 0, 0);
      repeat (260) @(negedge clk_i);
      req_valid_i = 1'b0;
      check("sat_drop", 32'(drop_cnt_o), 255);
      check("sat_valid", 32'(pkt_valid_o), 0);

      // Backpressure: four fill the FIFO, the fifth waits for a slot.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b1, 2, 0, i);
         check($sformatf("bp_ready%0d", i), 32'(req_ready_o), 1);
         @(negedge clk_i);
      end
      drive_req(1'b1, 2, 0, 4);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_full%0d", i), 32'(req_ready_o), 0);
         check($sformatf("bp_hold%0d", i), 32'(pkt_o), 32'(mk(2, 0, 0, 0)));
         check($sformatf("bp_valid%0d", i), 32'(pkt_valid_o), 1);
         @(negedge clk_i);
      end
      pkt_ready_i = 1'b1;
      cyc = 0;
      while (got.size() < 5 && cyc < 20) begin
         if (pkt_valid_o) got.push_back(pkt_o);
         took = req_valid_i && req_ready_o;
         @(negedge clk_i);
         if (took) req_valid_i = 1'b0;
         cyc++;
      end
      check("bp_count", 32'(got.size()), 5);
      for (int i = 0; i < got.size(); i++) begin
         check($sformatf("bp_order%0d", i), 32'(got[i]), 32'(mk(2, 0, i, i)));
      end
      req_valid_i = 1'b0;
      @(negedge clk_i);
      check("bp_sent", 32'(sent_cnt_o), 5);

      // Continuous streaming with seq wrap.
      do_reset();
      pkt_ready_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
         drive_req(1'b1, 3, 2, k);
         @(negedge clk_i);
         check($sformatf("str%0d_valid", k), 32'(pkt_valid_o), 1);
         check($sformatf("str%0d_pkt", k), 32'(pkt_o), 32'(mk(3, 2, k % 16, k)));
      end
      req_valid_i = 1'b0;
      @(negedge clk_i);
      check("str_sent", 32'(sent_cnt_o), 20);
      check("str_empty", 32'(pkt_valid_o), 0);

      // Reset with packets buffered.
      do_reset();
      drive_req(1'b1, 7, 0, 0);
      @(negedge clk_i);
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b1, 0, 2, i + 1);
         @(negedge clk_i);
      end
      req_valid_i = 1'b0;
      check("mid_valid_pre", 32'(pkt_valid_o), 1);
      check("mid_drop_pre", 32'(drop_cnt_o), 1);
      #2 rst_ni = 1'b0;
      #1;
      check("mid_valid", 32'(pkt_valid_o), 0);
      check("mid_drop", 32'(drop_cnt_o), 0);
      check("mid_ready", 32'(req_ready_o), 1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      pkt_ready_i = 1'b0;
      drive_req(1'b1, 0, 2, 8'hEE);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      check("mid_seq0", 32'(pkt_o), 32'(mk(0, 2, 0, 8'hEE)));

      // Randomized traffic against the queue model.
      do_reset();
      m_q.delete();
      m_seq  = 0;
      m_drop = 0;
      m_sent = 0;
      m_err  = 1'b0;
      repeat (2000) rnd_step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
